// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared CPU constants: ALU op codes, mult/div op and FSM encodings,
// iteration count, and a conditional two's-complement helper.
package hilo_muldiv_ctrl_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ACC_W    = 2 * DATA_W;
    localparam int unsigned MD_ITERS = 32;
    localparam int unsigned CNT_W    = 6;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Two's-complement negate when i_neg is set, pass through otherwise.
    function automatic logic [DATA_W-1:0] neg_if(input logic i_neg,
                                                 input logic [DATA_W-1:0] i_val);
        return i_neg ? DATA_W'(~i_val + 1'b1) : i_val;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_step.sv
// One iteration of the unsigned multiply / divide datapath (combinational).
//   i_div   : 0 = shift-add multiply, 1 = restoring shift-subtract divide
//   i_acc   : multiply {partial product, remaining multiplier bits}
//             divide   {partial remainder, remaining dividend / quotient bits}
//   i_opnd  : multiplicand (multiply) or divisor (divide)
//   o_acc_c : accumulator after this iteration
module muldiv_step
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic              i_div,
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_opnd,
    output logic [ACC_W-1:0]  o_acc_c
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_rem_sh;
    logic [DATA_W:0] w_diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB is set,
        // then shift the whole 65-bit result right by one.
        w_sum    = {1'b0, i_acc[ACC_W-1:DATA_W]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        // Divide: remainder shifted left with the next dividend bit; bit DATA_W
        // of the difference is the borrow (remainder smaller than divisor).
        w_rem_sh = i_acc[ACC_W-1:DATA_W-1];
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        if (i_div) begin
            if (w_diff[DATA_W]) begin
                o_acc_c = {w_rem_sh[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b0};
            end else begin
                o_acc_c = {w_diff[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
            end
        end else begin
            o_acc_c = {w_sum, i_acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, op, a, b    : operation request, sampled only while idle
//   hi_we, lo_we, wdata: MTHI/MTLO writes, honoured only while idle
//   hi, lo             : HI/LO registers
//   busy               : unit is not idle
//   done               : one-cycle completion pulse
//   div_zero           : sticky divide-by-zero flag, cleared by next accepted start
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    md_state_e          r_state;
    md_state_e          w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]  r_opnd;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    md_op_e             w_op;
    logic               w_accept;
    logic               w_is_div;
    logic               w_signed;
    logic               w_b_zero;
    logic [DATA_W-1:0]  w_a_mag;
    logic [DATA_W-1:0]  w_b_mag;
    logic [ACC_W-1:0]   w_acc_init;
    logic [DATA_W-1:0]  w_opnd_init;
    logic [ACC_W-1:0]   w_acc_step;
    logic [ACC_W-1:0]   w_prod;
    logic [DATA_W-1:0]  w_fix_hi;
    logic [DATA_W-1:0]  w_fix_lo;

    assign w_op     = md_op_e'(op);
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_b_zero = (b == '0);
    assign w_a_mag  = neg_if(w_signed && a[DATA_W-1], a);
    assign w_b_mag  = neg_if(w_signed && b[DATA_W-1], b);

    muldiv_step u_step (
        .i_div   (r_is_div),
        .i_acc   (r_acc),
        .i_opnd  (r_opnd),
        .o_acc_c (w_acc_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; divide by zero skips straight to DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = (w_is_div && w_b_zero) ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_cnt == CNT_W'(MD_ITERS - 1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand loading and sign fix-up of the finished magnitude result
    always_comb begin
        w_acc_init  = {{DATA_W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
        w_opnd_init = w_is_div ? w_b_mag : w_a_mag;
        w_prod      = r_neg_q ? ACC_W'(~r_acc + ACC_W'(1)) : r_acc;
        if (r_is_div) begin
            w_fix_hi = neg_if(r_neg_r, r_acc[ACC_W-1:DATA_W]);
            w_fix_lo = neg_if(r_neg_q, r_acc[DATA_W-1:0]);
        end else begin
            w_fix_hi = w_prod[ACC_W-1:DATA_W];
            w_fix_lo = w_prod[DATA_W-1:0];
        end
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE);
            if (r_state == ST_IDLE) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
            if (w_accept) begin
                r_cnt      <= '0;
                r_acc      <= w_acc_init;
                r_opnd     <= w_opnd_init;
                r_is_div   <= w_is_div;
                r_neg_q    <= w_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
                r_neg_r    <= w_signed && a[DATA_W-1];
                r_div_zero <= w_is_div && w_b_zero;
            end
            if (r_state == ST_RUN) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == ST_FIX) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases plus
// randomized operations compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one operation, from ordinary integer arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                      output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ez = 1'b0;
        eh = cur_hi;
        el = cur_lo;
        case (o)
            2'b00: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'h0, x} * {32'h0, y}; eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (y == 0) ez = 1'b1;
                else begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
            end
            default: begin
                if (y == 0) ez = 1'b1;
                else begin el = x / y; eh = x % y; end
            end
        endcase
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic mt(input logic is_hi, input logic [31:0] d);
        hi_we = is_hi;
        lo_we = !is_hi;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (is_hi) m_hi = d; else m_lo = d;
        check("mt hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    // Issue one operation (optionally with a same-cycle MTHI/MTLO and a
    // later ignored start+write while busy) and check latency and results.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic whi, input logic wlo, input logic [31:0] wd,
                          input int inj, input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
        int          explat;
        if (whi) m_hi = wd;
        if (wlo) m_lo = wd;
        ref_model(o, x, y, m_hi, m_lo, eh, el, ez);
        explat = ez ? 1 : 34;
        start = 1'b1; op = o; a = x; b = y; hi_we = whi; lo_we = wlo; wdata = wd;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                op = 2'($urandom); a = $urandom; b = $urandom; wdata = $urandom;
                check({tag, " busy"}, 64'(busy), 64'd1);
                check({tag, " dz early"}, 64'(div_zero), 64'(ez));
            end
            if (inj != 0 && i == inj) begin
                start = 1'b1; op = 2'b11; b = '0; hi_we = 1'b1; lo_we = 1'b1;
            end
            if (inj != 0 && i == inj + 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                check({tag, " held"}, {hi, lo}, {m_hi, m_lo});
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(explat));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " div_zero"}, 64'(div_zero), 64'(ez));
        m_hi = eh;
        m_lo = el;
        @(negedge clk);
        check({tag, " idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #3;
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset flags", 64'({busy, done, div_zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, '0, 0, "mult neg");
        check("mult neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 0, "multu max");
        check("multu max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 0, "div neg");
        check("div neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, '0, 0, "divu");
        check("divu const", {hi, lo}, {32'd2, 32'd14});
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 0, "div ovf");
        check("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, '0, 0, "div negb");

        mt(1'b0, 32'h0000_1234);
        run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, '0, 0, "divu zero");
        check("divu zero lo const", 64'(lo), 64'h1234);
        run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, '0, 0, "dz clear");

        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, '0, 8, "start busy");
        run_op(2'b11, 32'd9, 32'd0, 1'b1, 1'b1, 32'hCAFE_F00D, 0, "we+dz");
        check("we+dz const", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
        run_op(2'b00, 32'd6, 32'd7, 1'b1, 1'b0, 32'h5A5A_5A5A, 0, "we+mult");

        for (int n = 0; n < 24; n++) begin
            logic [1:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            int          sel;
            logic        whi;
            logic        wlo;
            o   = 2'($urandom_range(0, 3));
            x   = $urandom;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       y = '0;
                1:       y = $urandom_range(1, 15);
                2:       y = '1;
                3:       begin y = $urandom; x = 32'h8000_0000; end
                default: y = $urandom;
            endcase
            whi = ($urandom_range(0, 3) == 0);
            wlo = ($urandom_range(0, 3) == 0);
            run_op(o, x, y, whi, wlo, $urandom,
                   (n % 5 == 0) ? int'($urandom_range(2, 30)) : 0, "rnd");
        end

        // Reset in the middle of a multiply, after an ignored start+MTHI.
        mt(1'b1, 32'hAAAA_5555);
        start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 10) begin start = 1'b1; hi_we = 1'b1; wdata = 32'h1111_2222; end
            if (i == 11) begin
                start = 1'b0; hi_we = 1'b0;
                check("abort hi held", 64'(hi), 64'(m_hi));
                check("abort busy", 64'(busy), 64'd1);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort reset hilo", {hi, lo}, 64'd0);
        check("abort reset flags", 64'({busy, done, div_zero}), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        check("abort hilo after", {hi, lo}, 64'd0);
        run_op(2'b01, 32'd123456, 32'd654321, 1'b0, 1'b0, '0, 0, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
